// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan decoder family.
// State encoding and dwell-counter sizing live here so every user agrees on them.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    // Dwell counter never narrower than one bit, even for DWELL of 1 or 2.
    function automatic int cnt_width(input int dwell);
        return (dwell <= 2) ? 1 : $clog2(dwell);
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Purpose: combinational N-to-2^N one-hot decoder with enable (all-zero when disabled).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; no flow control.
module onehot_dec #(
    parameter int N = 3
) (
    input  logic                 en,
    input  logic [N-1:0]         sel,
    output logic [(1<<N)-1:0]    y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// Purpose: registered N-to-2^N line decoder with direct (latched select) and auto-scan modes.
// Latency: 1 cycle from inputs to Y/idx/wrap/active.
// Backpressure: none; inputs are sampled every cycle, outputs are free-running strobes.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 mode,
    input  logic                 load,
    input  logic [N-1:0]         sel,
    output logic [(1<<N)-1:0]    Y,
    output logic [N-1:0]         idx,
    output logic                 wrap,
    output logic                 active
);

    localparam int W  = 1 << N;
    localparam int CW = cnt_width(DWELL);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [N-1:0]     idx_nxt, dec_idx, idx_inc;
    logic [W-1:0]     y_nxt, dec_y;
    logic             dec_en, hold_y, wrap_nxt;

    assign idx_inc = idx + N'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            OFF:     if (enable) state_nxt = mode ? SCAN : DIRECT;
            DIRECT:  if (!enable) state_nxt = OFF;
                     else if (mode) state_nxt = SCAN;
            SCAN:    if (!enable) state_nxt = OFF;
                     else if (!mode) state_nxt = DIRECT;
            default: state_nxt = OFF;
        endcase
    end

    // Next values for the registered outputs. A seed (entering scan or a
    // reseed) and a direct load both route sel through the decoder; a scan
    // step routes idx+1 through it instead.
    always_comb begin
        dec_en   = 1'b0;
        dec_idx  = idx;
        hold_y   = 1'b1;
        idx_nxt  = idx;
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        case (state)
            OFF: begin
                hold_y = 1'b0;
                if (enable && (mode || load)) begin
                    dec_en  = 1'b1;
                    dec_idx = sel;
                    idx_nxt = sel;
                    if (mode) cnt_nxt = '0;
                end
            end
            DIRECT: begin
                if (!enable) begin
                    hold_y = 1'b0;
                end else if (mode || load) begin
                    dec_en  = 1'b1;
                    dec_idx = sel;
                    idx_nxt = sel;
                    if (mode) cnt_nxt = '0;
                end
            end
            SCAN: begin
                if (!enable) begin
                    hold_y  = 1'b0;
                    cnt_nxt = '0;
                end else if (!mode) begin
                    hold_y = 1'b1;
                end else if (load) begin
                    dec_en  = 1'b1;
                    dec_idx = sel;
                    idx_nxt = sel;
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    dec_en   = 1'b1;
                    dec_idx  = idx_inc;
                    idx_nxt  = idx_inc;
                    cnt_nxt  = '0;
                    wrap_nxt = &idx;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: hold_y = 1'b0;
        endcase
        y_nxt = dec_en ? dec_y : (hold_y ? Y : '0);
    end

    onehot_dec #(.N(N)) u_dec (
        .en  (dec_en),
        .sel (dec_idx),
        .y   (dec_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y      <= '0;
            idx    <= '0;
            cnt    <= '0;
            wrap   <= 1'b0;
            active <= 1'b0;
        end else begin
            Y      <= y_nxt;
            idx    <= idx_nxt;
            cnt    <= cnt_nxt;
            wrap   <= wrap_nxt;
            active <= (state_nxt != OFF);
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: two instances (DWELL=4 and DWELL=1) share stimulus,
// a per-cycle reference model checks both, and literal expectations pin key points.
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0, mode = 1'b0, load = 1'b0;
    logic [2:0] sel = '0;
    logic [7:0] y0, y1;
    logic [2:0] idx0, idx1;
    logic       wrap0, wrap1, act0, act1;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    scan_decoder #(.N(3), .DWELL(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .load(load),
        .sel(sel), .Y(y0), .idx(idx0), .wrap(wrap0), .active(act0));

    scan_decoder #(.N(3), .DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .load(load),
        .sel(sel), .Y(y1), .idx(idx1), .wrap(wrap1), .active(act1));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model, one slot per instance. m_st: 0 off, 1 direct, 2 scan.
    int m_st[2], m_idx[2], m_cnt[2], m_wrap[2], m_show[2];
    int m_dw[2] = '{4, 1};

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_st[k] = 0; m_idx[k] = 0; m_cnt[k] = 0; m_wrap[k] = 0; m_show[k] = 0;
            end else begin
                m_wrap[k] = 0;
                if (!enable) begin
                    if (m_st[k] == 2) m_cnt[k] = 0;
                    m_st[k] = 0;
                    m_show[k] = 0;
                end else if (mode && (m_st[k] != 2 || load)) begin
                    m_st[k] = 2; m_idx[k] = sel; m_show[k] = 1; m_cnt[k] = 0;
                end else if (!mode) begin
                    if (m_st[k] == 0) m_show[k] = 0;
                    if (m_st[k] != 2 && load) begin
                        m_idx[k] = sel; m_show[k] = 1;
                    end
                    m_st[k] = 1;
                end else if (m_cnt[k] + 1 >= m_dw[k]) begin
                    m_cnt[k] = 0;
                    m_wrap[k] = (m_idx[k] == 7) ? 1 : 0;
                    m_idx[k] = (m_idx[k] + 1) % 8;
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end
        end
    end

    function automatic logic [7:0] exp_y(input int k);
        return (m_show[k] != 0) ? 8'(1 << m_idx[k]) : 8'h00;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_y0",    32'(y0),    32'(exp_y(0)));
            check("model_idx0",  32'(idx0),  32'(m_idx[0]));
            check("model_wrap0", 32'(wrap0), 32'(m_wrap[0]));
            check("model_act0",  32'(act0),  32'(m_st[0] != 0));
            check("model_y1",    32'(y1),    32'(exp_y(1)));
            check("model_idx1",  32'(idx1),  32'(m_idx[1]));
            check("model_wrap1", 32'(wrap1), 32'(m_wrap[1]));
            check("model_act1",  32'(act1),  32'(m_st[1] != 0));
        end
    end

    // Called at a falling edge: apply inputs, return at the next falling edge.
    task automatic drive(input logic e, input logic m, input logic l, input logic [2:0] s);
        enable = e; mode = m; load = l; sel = s;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
            check("rst_y", 32'(y0), 32'h0);
            check("rst_idx", 32'(idx0), 32'h0);
            check("rst_active", 32'(act0), 32'h0);
            check("rst_wrap", 32'(wrap0), 32'h0);
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0);
        check("off_active", 32'(act0), 32'h0);

        // Direct mode
        drive(1, 0, 1, 5);
        check("dir_load_y", 32'(y0), 32'h20);
        check("dir_load_idx", 32'(idx0), 32'h5);
        check("dir_active", 32'(act0), 32'h1);
        drive(1, 0, 0, 2);
        check("dir_hold_y", 32'(y0), 32'h20);
        drive(0, 0, 0, 2);
        check("dir_off_y", 32'(y0), 32'h0);
        check("dir_off_active", 32'(act0), 32'h0);
        check("dir_off_idx", 32'(idx0), 32'h5);

        // Scan walk from OFF starting at 6
        drive(1, 1, 0, 6);
        check("scan_start_y", 32'(y0), 32'h40);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0);
            check("scan_dwell6_y", 32'(y0), 32'h40);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0);
            check("scan_dwell7_y", 32'(y0), 32'h80);
            check("scan_dwell7_wrap", 32'(wrap0), 32'h0);
        end
        drive(1, 1, 0, 0);
        check("scan_wrap_y", 32'(y0), 32'h01);
        check("scan_wrap_pulse", 32'(wrap0), 32'h1);
        drive(1, 1, 0, 0);
        check("scan_wrap_once", 32'(wrap0), 32'h0);
        drive(1, 1, 0, 0);
        drive(1, 1, 0, 0);
        drive(1, 1, 0, 0);
        check("scan_next_y", 32'(y0), 32'h02);

        // Reach idx 2, then reseed to 0
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 0);
        check("scan_idx2", 32'(idx0), 32'h2);
        drive(1, 1, 1, 0);
        check("reseed_y", 32'(y0), 32'h01);
        check("reseed_wrap", 32'(wrap0), 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0);
            check("reseed_dwell_y", 32'(y0), 32'h01);
        end
        drive(1, 1, 0, 0);
        check("reseed_step_y", 32'(y0), 32'h02);

        // Reach idx 3, freeze in DIRECT, resume scan at 7
        for (int i = 0; i < 8; i++) drive(1, 1, 0, 0);
        check("mode_idx3", 32'(idx0), 32'h3);
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 3'($urandom));
            check("mode_frozen_y", 32'(y0), 32'h08);
        end
        drive(1, 1, 0, 7);
        check("mode_rescan_y", 32'(y0), 32'h80);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0);
            check("mode_rescan_dwell", 32'(y0), 32'h80);
        end
        drive(1, 1, 0, 0);
        check("mode_rescan_wrap", 32'(wrap0), 32'h1);

        // Exhaustive direct decode
        drive(1, 0, 0, 0);
        for (int s = 0; s < 8; s++) begin
            drive(1, 0, 1, 3'(s));
            check("exh_y", 32'(y0), 32'(1 << s));
            check("exh_idx", 32'(idx0), 32'(s));
        end

        // DWELL=1 instance: advances every cycle, wraps every 8
        drive(1, 1, 0, 0);
        check("dw1_start_idx", 32'(idx1), 32'h0);
        for (int i = 1; i <= 16; i++) begin
            drive(1, 1, 0, 0);
            check("dw1_idx", 32'(idx1), 32'(i % 8));
            check("dw1_wrap", 32'(wrap1), 32'((i % 8) == 0));
        end

        // Asynchronous reset between edges
        chk_on = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_y", 32'(y0), 32'h0);
        check("async_active", 32'(act0), 32'h0);
        check("async_idx", 32'(idx0), 32'h0);
        @(negedge clk);
        chk_on = 1'b1;
        rst_n = 1'b1;
        drive(0, 1, 0, 4);
        check("post_rst_active", 32'(act0), 32'h0);
        check("post_rst_y", 32'(y0), 32'h0);
        drive(1, 1, 0, 4);
        check("post_rst_scan_y", 32'(y0), 32'h10);
        chk_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
